// File: rtl/vga_capture.sv
// vga_capture: sink side of a 12-bit VGA link. Samples RGB/HS/VS on PIX_EN,
// recovers line/frame position, checks timing against the expected
// parameters and reports lock. Captured active pixels come out one clock
// after the sampling edge with their active-area coordinates.
// Optional per-frame checksum of captured pixels is built only when the
// macro VGA_CAP_CHECKSUM_EN is defined; otherwise FRAME_SUM/SUM_VALID are 0.
module vga_capture #(
    parameter int HTOTAL      = 800,
    parameter int VTOTAL      = 525,
    parameter int HBLANK      = 144,
    parameter int VBLANK      = 35,
    parameter int HACTIVE     = 640,
    parameter int VACTIVE     = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PIX_EN,
    input  logic [3:0]  VGA_R,
    input  logic [3:0]  VGA_G,
    input  logic [3:0]  VGA_B,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    output logic [9:0]  PIX_X,
    output logic [9:0]  PIX_Y,
    output logic [11:0] PIX_RGB,
    output logic        PIX_VALID,
    output logic        FRAME_START,
    output logic        LOCKED,
    output logic [9:0]  LINE_LEN,
    output logic [9:0]  FRAME_LINES,
    output logic [31:0] FRAME_SUM,
    output logic        SUM_VALID
);

    // Widened constants so that count+1 and window ends never wrap.
    localparam logic [10:0] C_HTOTAL = 11'(HTOTAL);
    localparam logic [10:0] C_VTOTAL = 11'(VTOTAL);
    localparam logic [11:0] C_HSTART = 12'(HBLANK);
    localparam logic [11:0] C_HEND   = 12'(HBLANK + HACTIVE);
    localparam logic [11:0] C_VSTART = 12'(VBLANK);
    localparam logic [11:0] C_VEND   = 12'(VBLANK + VACTIVE);
    localparam logic [9:0]  C_HOFS   = 10'(HBLANK);
    localparam logic [9:0]  C_VOFS   = 10'(VBLANK);
    localparam logic [3:0]  C_LOCK   = 4'(LOCK_FRAMES);

    // Timing-tracker state
    logic        r_hs_prev;
    logic        r_vs_prev;
    logic [9:0]  r_hcnt;
    logic [9:0]  r_vcnt;
    logic        r_line_seen;
    logic        r_vs_pending;
    logic        r_frame_seen;
    logic        r_frame_bad;
    logic [3:0]  r_lock_cnt;
    logic        r_locked;

    // Registered outputs
    logic [9:0]  r_pix_x;
    logic [9:0]  r_pix_y;
    logic [11:0] r_pix_rgb;
    logic        r_pix_valid;
    logic        r_frame_start;
    logic [9:0]  r_line_len;
    logic [9:0]  r_frame_lines;

    // Decoded per-sample events
    logic        w_hs_fall;
    logic        w_vs_fall;
    logic [10:0] w_line_len;
    logic [10:0] w_frame_lines;
    logic        w_bad_line;
    logic        w_frame_hit;
    logic        w_good_frame;
    logic [9:0]  w_hcnt_next;
    logic [9:0]  w_vcnt_inc;
    logic [9:0]  w_vcnt_next;
    logic        w_vcnt_overrun;
    logic        w_h_active;
    logic        w_v_active;
    logic        w_pix_take;
    logic [11:0] w_rgb;
    logic [3:0]  w_lock_cnt_next;
    logic        w_locked_next;

    assign w_rgb       = {VGA_R, VGA_G, VGA_B};
    assign w_hs_fall   = PIX_EN && !VGA_HS && r_hs_prev;
    assign w_vs_fall   = PIX_EN && !VGA_VS && r_vs_prev;

    // Length of the line ending at this HS fall; only meaningful once a
    // full line start has been observed.
    assign w_line_len  = {1'b0, r_hcnt} + 11'd1;
    assign w_bad_line  = w_hs_fall && r_line_seen && (w_line_len != C_HTOTAL);

    // A pending (or simultaneous) VS fall turns the next HS fall into line 0.
    assign w_frame_hit   = w_hs_fall && (r_vs_pending || w_vs_fall);
    assign w_frame_lines = {1'b0, r_vcnt} + 11'd1;
    // The bad-line test on this very edge belongs to the frame now ending.
    assign w_good_frame  = r_frame_seen && !r_frame_bad && !w_bad_line &&
                           (w_frame_lines == C_VTOTAL);

    assign w_hcnt_next = w_hs_fall ? 10'd0 :
                         (r_hcnt == 10'h3FF) ? r_hcnt : r_hcnt + 10'd1;
    assign w_vcnt_inc  = (r_vcnt == 10'h3FF) ? r_vcnt : r_vcnt + 10'd1;
    assign w_vcnt_next = w_frame_hit ? 10'd0 :
                         w_hs_fall   ? w_vcnt_inc : r_vcnt;

    // Frame ran past its expected height with no VS in sight.
    assign w_vcnt_overrun = w_hs_fall && !w_frame_hit &&
                            ({1'b0, w_vcnt_next} == C_VTOTAL);

    // Active window is judged on the counter values given to this sample.
    assign w_h_active = ({2'b00, w_hcnt_next} >= C_HSTART) &&
                        ({2'b00, w_hcnt_next} <  C_HEND);
    assign w_v_active = ({2'b00, w_vcnt_next} >= C_VSTART) &&
                        ({2'b00, w_vcnt_next} <  C_VEND);
    assign w_pix_take = PIX_EN && w_h_active && w_v_active && r_locked;

    // Next lock counter: frame boundaries build it up, timing errors zero it.
    always_comb begin
        w_lock_cnt_next = r_lock_cnt;
        if (w_frame_hit) begin
            if (w_good_frame) begin
                w_lock_cnt_next = (r_lock_cnt == 4'hF) ? r_lock_cnt
                                                       : r_lock_cnt + 4'd1;
            end else begin
                w_lock_cnt_next = 4'd0;
            end
        end
        if (w_bad_line || w_vcnt_overrun) begin
            w_lock_cnt_next = 4'd0;
        end
    end

    assign w_locked_next = (w_lock_cnt_next >= C_LOCK);

    // Line/frame position and timing measurement.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hs_prev     <= 1'b0;
            r_vs_prev     <= 1'b0;
            r_hcnt        <= 10'd0;
            r_vcnt        <= 10'd0;
            r_line_seen   <= 1'b0;
            r_vs_pending  <= 1'b0;
            r_frame_seen  <= 1'b0;
            r_frame_bad   <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_len    <= 10'd0;
            r_frame_lines <= 10'd0;
        end else begin
            r_frame_start <= 1'b0;
            if (PIX_EN) begin
                r_hs_prev <= VGA_HS;
                r_vs_prev <= VGA_VS;
                r_hcnt    <= w_hcnt_next;
                r_vcnt    <= w_vcnt_next;
                if (w_hs_fall) begin
                    r_line_seen <= 1'b1;
                    if (r_line_seen) begin
                        r_line_len <= w_line_len[9:0];
                    end
                end
                if (w_frame_hit) begin
                    r_vs_pending  <= 1'b0;
                    r_frame_seen  <= 1'b1;
                    r_frame_bad   <= 1'b0;
                    r_frame_start <= 1'b1;
                    if (r_frame_seen) begin
                        r_frame_lines <= w_frame_lines[9:0];
                    end
                end else begin
                    if (w_vs_fall) begin
                        r_vs_pending <= 1'b1;
                    end
                    if (w_bad_line) begin
                        r_frame_bad <= 1'b1;
                    end
                end
            end
        end
    end

    // Lock counter and registered lock flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lock_cnt <= 4'd0;
            r_locked   <= 1'b0;
        end else begin
            r_lock_cnt <= w_lock_cnt_next;
            r_locked   <= w_locked_next;
        end
    end

    // Pixel capture: pulse valid and update coordinates for locked active samples.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pix_x     <= 10'd0;
            r_pix_y     <= 10'd0;
            r_pix_rgb   <= 12'd0;
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_valid <= w_pix_take;
            if (w_pix_take) begin
                r_pix_x   <= w_hcnt_next - C_HOFS;
                r_pix_y   <= w_vcnt_next - C_VOFS;
                r_pix_rgb <= w_rgb;
            end
        end
    end

`ifdef VGA_CAP_CHECKSUM_EN
    logic [31:0] r_acc;
    logic [31:0] r_frame_sum;
    logic        r_sum_valid;
    logic        r_sum_ok;

    // Per-frame checksum; published only for good frames locked end to end.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_acc       <= 32'd0;
            r_frame_sum <= 32'd0;
            r_sum_valid <= 1'b0;
            r_sum_ok    <= 1'b0;
        end else begin
            r_sum_valid <= 1'b0;
            if (PIX_EN) begin
                if (w_frame_hit) begin
                    if (w_good_frame && r_sum_ok) begin
                        r_frame_sum <= r_acc;
                        r_sum_valid <= 1'b1;
                    end
                    r_acc    <= w_pix_take ? {20'd0, w_rgb} : 32'd0;
                    r_sum_ok <= w_locked_next;
                end else begin
                    if (w_pix_take) begin
                        r_acc <= r_acc + {20'd0, w_rgb};
                    end
                    if (!w_locked_next) begin
                        r_sum_ok <= 1'b0;
                    end
                end
            end
        end
    end

    assign FRAME_SUM = r_frame_sum;
    assign SUM_VALID = r_sum_valid;
`else
    assign FRAME_SUM = 32'd0;
    assign SUM_VALID = 1'b0;
`endif

    assign PIX_X       = r_pix_x;
    assign PIX_Y       = r_pix_y;
    assign PIX_RGB     = r_pix_rgb;
    assign PIX_VALID   = r_pix_valid;
    assign FRAME_START = r_frame_start;
    assign LOCKED      = r_locked;
    assign LINE_LEN    = r_line_len;
    assign FRAME_LINES = r_frame_lines;

endmodule

// File: tb/tb_vga_capture.sv
// Testbench for vga_capture using a reduced raster (24x14 total, 12x8 active)
// so many frames fit in a short run. A scripted generator drives frames from
// a table; a line/frame-level reference model predicts every output.
module tb_vga_capture;

    localparam int HT = 24;
    localparam int VT = 14;
    localparam int HB = 6;
    localparam int VB = 3;
    localparam int HA = 12;
    localparam int VA = 8;
    localparam int LF = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_en = 1'b0;
    logic [3:0]  vga_r = '0, vga_g = '0, vga_b = '0;
    logic        vga_hs = 1'b1, vga_vs = 1'b1;
    logic [9:0]  pix_x, pix_y, line_len, frame_lines;
    logic [11:0] pix_rgb;
    logic        pix_valid, frame_start, locked, sum_valid;
    logic [31:0] frame_sum;

    vga_capture #(
        .HTOTAL(HT), .VTOTAL(VT), .HBLANK(HB), .VBLANK(VB),
        .HACTIVE(HA), .VACTIVE(VA), .LOCK_FRAMES(LF)
    ) dut (
        .CLK(clk), .RST(rst), .PIX_EN(pix_en),
        .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
        .VGA_HS(vga_hs), .VGA_VS(vga_vs),
        .PIX_X(pix_x), .PIX_Y(pix_y), .PIX_RGB(pix_rgb),
        .PIX_VALID(pix_valid), .FRAME_START(frame_start), .LOCKED(locked),
        .LINE_LEN(line_len), .FRAME_LINES(frame_lines),
        .FRAME_SUM(frame_sum), .SUM_VALID(sum_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cur_f = 0, cur_l = 0, cur_c = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s frame=%0d line=%0d col=%0d got=%0h expected=%0h",
                     name, cur_f, cur_l, cur_c, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model (generator coordinates) ----------------
    bit          m_have_line, m_have_frame, m_frame_ok, m_locked, m_sum_ok;
    int          m_vline, m_good;
    logic [31:0] m_acc;
    logic [9:0]  e_x, e_y, e_len, e_flines;
    logic [11:0] e_rgb;
    bit          e_valid, e_fs, e_sumv;
    logic [31:0] e_sum;
    int          g_prev_len;
    int          g_valid_cnt;

    task automatic model_reset();
        m_have_line = 0; m_have_frame = 0; m_frame_ok = 0; m_locked = 0;
        m_sum_ok = 0; m_vline = 0; m_good = 0; m_acc = 0;
        e_x = 0; e_y = 0; e_len = 0; e_flines = 0; e_rgb = 0;
        e_valid = 0; e_fs = 0; e_sumv = 0; e_sum = 0;
    endtask

    // Called when the generator starts a line (its first sample has HS low).
    task automatic model_line_start(input bit vs_frame, input int prev_len);
        bit bad, good;
        bad = m_have_line && (prev_len != HT);
        if (m_have_line) e_len = 10'(prev_len);
        if (vs_frame) begin
            good = m_have_frame && m_frame_ok && !bad && (m_vline + 1 == VT);
            e_fs = 1;
            if (m_have_frame) e_flines = 10'(m_vline + 1);
`ifdef VGA_CAP_CHECKSUM_EN
            if (good && m_sum_ok) begin
                e_sum = m_acc;
                e_sumv = 1;
            end
`endif
            m_good = good ? ((m_good < 15) ? m_good + 1 : 15) : 0;
            m_vline = 0; m_frame_ok = 1; m_have_frame = 1; m_acc = 0;
            m_locked = (m_good >= LF);
            m_sum_ok = m_locked;
        end else begin
            if (bad) begin
                m_frame_ok = 0;
                m_good = 0;
            end
            m_vline = (m_vline < 1023) ? m_vline + 1 : 1023;
            if (m_vline == VT) m_good = 0;
            m_locked = (m_good >= LF);
            if (!m_locked) m_sum_ok = 0;
        end
        m_have_line = 1;
    endtask

    task automatic check_all();
        chk("PIX_VALID", 32'(pix_valid), 32'(e_valid));
        chk("FRAME_START", 32'(frame_start), 32'(e_fs));
        chk("LOCKED", 32'(locked), 32'(m_locked));
        chk("PIX_X", 32'(pix_x), 32'(e_x));
        chk("PIX_Y", 32'(pix_y), 32'(e_y));
        chk("PIX_RGB", 32'(pix_rgb), 32'(e_rgb));
        chk("LINE_LEN", 32'(line_len), 32'(e_len));
        chk("FRAME_LINES", 32'(frame_lines), 32'(e_flines));
        chk("SUM_VALID", 32'(sum_valid), 32'(e_sumv));
        chk("FRAME_SUM", frame_sum, e_sum);
    endtask

    task automatic idle_cycle();
        pix_en = 1'b0;
        @(negedge clk);
        chk("idle PIX_VALID", 32'(pix_valid), 32'd0);
        chk("idle FRAME_START", 32'(frame_start), 32'd0);
        chk("idle SUM_VALID", 32'(sum_valid), 32'd0);
        chk("idle PIX_X", 32'(pix_x), 32'(e_x));
    endtask

    task automatic do_sample(input logic hs, input logic vs, input logic [11:0] rgb,
                             input bit lstart, input bit fstart, input int col);
        int gap;
        bit lk_before, act;
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) idle_cycle();
        lk_before = m_locked;
        e_fs = 0; e_sumv = 0; e_valid = 0;
        if (lstart) model_line_start(fstart, g_prev_len);
        act = (col >= HB) && (col < HB + HA) && (m_vline >= VB) &&
              (m_vline < VB + VA) && lk_before;
        if (act) begin
            e_valid = 1;
            e_x = 10'(col - HB);
            e_y = 10'(m_vline - VB);
            e_rgb = rgb;
            m_acc = m_acc + 32'(rgb);
        end
        pix_en = 1'b1; vga_hs = hs; vga_vs = vs;
        {vga_r, vga_g, vga_b} = rgb;
        @(negedge clk);
        pix_en = 1'b0;
        if (pix_valid) g_valid_cnt++;
        check_all();
    endtask

    task automatic do_reset(input bit busy);
        rst = 1'b1;
        pix_en = busy; vga_hs = 1'b0; vga_vs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst PIX_VALID", 32'(pix_valid), 32'd0);
        chk("rst FRAME_START", 32'(frame_start), 32'd0);
        chk("rst LOCKED", 32'(locked), 32'd0);
        chk("rst PIX_X", 32'(pix_x), 32'd0);
        chk("rst PIX_Y", 32'(pix_y), 32'd0);
        chk("rst PIX_RGB", 32'(pix_rgb), 32'd0);
        chk("rst LINE_LEN", 32'(line_len), 32'd0);
        chk("rst FRAME_LINES", 32'(frame_lines), 32'd0);
        chk("rst FRAME_SUM", frame_sum, 32'd0);
        chk("rst SUM_VALID", 32'(sum_valid), 32'd0);
        rst = 1'b0; pix_en = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1;
        model_reset();
        // Tail of a line with both syncs high before the first real line.
        for (int i = 0; i < 5; i++) do_sample(1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 1000);
    endtask

    function automatic logic [11:0] src_rgb(input int mode, input int c, input int ln);
        logic [11:0] v;
        case (mode)
            0: v = 12'h000;
            1: v = 12'(c * 37 + ln * 101 + 5);
            2: v = 12'($urandom);
            default: v = 12'hFFF;
        endcase
        return v;
    endfunction

    // ---------------- frame script ----------------
    typedef struct {
        bit vs;          // VS asserted at line 0
        int short_line;  // line with HT-1 samples, -1 for none
        bit rst_mid;     // reset at line 7 of this frame
        bit gap;         // 1000-cycle PIX_EN gap mid-line
        int mode;        // pixel source
        bit exp_locked;  // LOCKED after this frame's first sample
        int exp_flines;  // FRAME_LINES after this frame's first sample
    } frame_t;

    frame_t tbl[17];

    task automatic run_frame(input int fi);
        frame_t rec;
        int len;
        logic hs, vs;
        rec = tbl[fi];
        g_valid_cnt = 0;
        for (int ln = 0; ln < VT; ln++) begin
            len = (ln == rec.short_line) ? HT - 1 : HT;
            for (int c = 0; c < len; c++) begin
                cur_f = fi; cur_l = ln; cur_c = c;
                if (rec.rst_mid && ln == 7 && c == 0) begin
                    do_reset(1'b1);
                    return;
                end
                if (rec.gap && ln == 5 && c == 10) begin
                    for (int i = 0; i < 1000; i++) idle_cycle();
                end
                hs = (c < 3) ? 1'b0 : 1'b1;
                vs = (rec.vs && ln < 2) ? 1'b0 : 1'b1;
                do_sample(hs, vs, src_rgb(rec.mode, c, ln), c == 0,
                          (c == 0) && (ln == 0) && rec.vs, c);
                if (ln == 0 && c == 0) begin
                    chk("tbl LOCKED", 32'(locked), 32'(rec.exp_locked));
                    chk("tbl FRAME_LINES", 32'(frame_lines), 32'(rec.exp_flines));
                    chk("tbl FRAME_START", 32'(frame_start), 32'(rec.vs));
                end
            end
            g_prev_len = len;
        end
        if (fi == 3) chk("pixels per locked frame", 32'(g_valid_cnt), 32'(HA * VA));
    endtask

    initial begin
        //            vs short rst gap mode lock flines
        tbl[0]  = '{1'b1, -1, 1'b0, 1'b0, 0, 1'b0, 0};
        tbl[1]  = '{1'b1, -1, 1'b0, 1'b0, 0, 1'b0, 14};
        tbl[2]  = '{1'b1, -1, 1'b0, 1'b0, 0, 1'b1, 14};
        tbl[3]  = '{1'b1, -1, 1'b0, 1'b0, 1, 1'b1, 14};
        tbl[4]  = '{1'b1,  5, 1'b0, 1'b0, 2, 1'b1, 14};
        tbl[5]  = '{1'b1, -1, 1'b0, 1'b0, 2, 1'b0, 14};
        tbl[6]  = '{1'b1, -1, 1'b0, 1'b0, 2, 1'b0, 14};
        tbl[7]  = '{1'b1, -1, 1'b0, 1'b0, 1, 1'b1, 14};
        tbl[8]  = '{1'b0, -1, 1'b0, 1'b0, 2, 1'b0, 14};
        tbl[9]  = '{1'b1, -1, 1'b0, 1'b0, 2, 1'b0, 28};
        tbl[10] = '{1'b1, -1, 1'b0, 1'b0, 2, 1'b0, 14};
        tbl[11] = '{1'b1, -1, 1'b0, 1'b0, 2, 1'b1, 14};
        tbl[12] = '{1'b1, -1, 1'b0, 1'b1, 3, 1'b1, 14};
        tbl[13] = '{1'b1, -1, 1'b1, 1'b0, 0, 1'b1, 14};
        tbl[14] = '{1'b1, -1, 1'b0, 1'b0, 1, 1'b0, 0};
        tbl[15] = '{1'b1, -1, 1'b0, 1'b0, 2, 1'b0, 14};
        tbl[16] = '{1'b1, -1, 1'b0, 1'b0, 1, 1'b1, 14};

        g_prev_len = HT;
        g_valid_cnt = 0;
        model_reset();
        @(negedge clk);
        do_reset(1'b0);
        for (int fi = 0; fi < 17; fi++) run_frame(fi);
        // A final frame start closes out the last scripted frame.
        cur_f = 17; cur_l = 0; cur_c = 0;
        do_sample(1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 0);
        chk("final LOCKED", 32'(locked), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
